// File: rtl/dm01_break_arbiter_if.sv
// Data-break arbitration bus: channel requests/acks, CPU break handshake and the
// TP4 memory-cycle strobe.
//   master : the arbiter side (drives brk_rq, grant, chan, ack, busy, stall)
//   slave  : the CPU/peripheral side (drives tp4, b_brk, req, stall_clr)
interface dm01_break_arbiter_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CHW = 2
);
   logic           tp4;
   logic           b_brk;
   logic [NCH-1:0] req;
   logic           stall_clr;
   logic           brk_rq;
   logic [NCH-1:0] grant;
   logic [CHW-1:0] chan;
   logic [NCH-1:0] ack;
   logic           busy;
   logic           stall;

   modport master (
      input  tp4, b_brk, req, stall_clr,
      output brk_rq, grant, chan, ack, busy, stall
   );

   modport slave (
      output tp4, b_brk, req, stall_clr,
      input  brk_rq, grant, chan, ack, busy, stall
   );
endinterface

// File: rtl/dm01_break_arbiter.sv
// PDP-8/I data-break arbiter. Shares the single DMA break path among NCH channels,
// arbitrating only on TP4 strobes so bus steering never changes mid memory cycle.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : dm01_break_arbiter_if.master
//              in : tp4, b_brk, req[NCH], stall_clr
//              out: brk_rq, grant[NCH] (one-hot), chan[CHW], ack[NCH] (1-clk pulse),
//                   busy, stall (sticky)
module dm01_break_arbiter #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned CHW         = 2,
   parameter int unsigned ROUND_ROBIN = 0,
   parameter int unsigned MAX_WAIT    = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   dm01_break_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StPend, StBrk} state_e;

   state_e         state_q, state_d;
   logic [CHW-1:0] win_q, win_d;
   logic [CHW-1:0] ptr_q, ptr_d;
   logic [7:0]     wait_q, wait_d;
   logic [NCH-1:0] ack_q, ack_d;
   logic           stall_q, stall_d;

   logic [NCH-1:0] win_oh;
   logic [CHW-1:0] win_nxt;
   logic [CHW:0]   pick_res;
   logic           stall_set;

   // Returns {found, index}: first set bit of cand searching upward from start, wrapping at NCH.
   function automatic logic [CHW:0] pick(input logic [NCH-1:0] cand, input logic [CHW-1:0] start);
      logic [CHW:0] res;
      logic [CHW:0] idx;
      res = '0;
      // Descending scan so the candidate closest to start overwrites the others.
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         idx = {1'b0, start} + (CHW+1)'(k);
         if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
         if (cand[idx[CHW-1:0]]) res = {1'b1, idx[CHW-1:0]};
      end
      return res;
   endfunction

   assign win_oh  = NCH'(1) << win_q;
   assign win_nxt = (win_q == CHW'(NCH - 1)) ? '0 : win_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      wait_d    = wait_q;
      ack_d     = '0;
      stall_set = 1'b0;
      pick_res  = '0;
      unique case (state_q)
         StIdle: begin
            if (bus.tp4) begin
               pick_res = pick(bus.req, (ROUND_ROBIN != 0) ? ptr_q : '0);
               if (pick_res[CHW]) begin
                  state_d = StPend;
                  win_d   = pick_res[CHW-1:0];
                  wait_d  = '0;
               end
            end
         end
         StPend: begin
            if (bus.b_brk) begin
               // CPU entering break wins over a coincident TP4.
               state_d = StBrk;
               wait_d  = '0;
            end else if (bus.tp4) begin
               if (!bus.req[win_q]) begin
                  // Winner withdrew: re-arbitrate without acking it.
                  pick_res = pick(bus.req, (ROUND_ROBIN != 0) ? ptr_q : '0);
                  wait_d   = '0;
                  if (pick_res[CHW]) begin
                     win_d = pick_res[CHW-1:0];
                  end else begin
                     state_d = StIdle;
                     win_d   = '0;
                  end
               end else begin
                  if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
                  if (wait_d >= 8'(MAX_WAIT)) stall_set = 1'b1;
               end
            end
         end
         StBrk: begin
            wait_d = '0;
            if (bus.tp4) begin
               ack_d    = win_oh;
               ptr_d    = win_nxt;
               // Mask the channel just served so its still-high req cannot win again.
               pick_res = pick(bus.req & ~win_oh, (ROUND_ROBIN != 0) ? win_nxt : '0);
               if (pick_res[CHW]) begin
                  state_d = StPend;
                  win_d   = pick_res[CHW-1:0];
               end else begin
                  state_d = StIdle;
                  win_d   = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            win_d   = '0;
         end
      endcase
      stall_d = stall_set | (stall_q & ~bus.stall_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         win_q   <= '0;
         ptr_q   <= '0;
         wait_q  <= '0;
         ack_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         wait_q  <= wait_d;
         ack_q   <= ack_d;
         stall_q <= stall_d;
      end
   end

   assign bus.brk_rq = (state_q == StPend);
   assign bus.busy   = (state_q != StIdle);
   assign bus.grant  = (state_q != StIdle) ? win_oh : '0;
   assign bus.chan   = (state_q != StIdle) ? win_q : '0;
   assign bus.ack    = ack_q;
   assign bus.stall  = stall_q;

endmodule

// File: tb/tb_dm01_break_arbiter.sv
module tb_dm01_break_arbiter;

   logic       clk;
   logic       rst;
   logic       tp4_v, bbrk_v, sclr_v;
   logic [7:0] req_v [3];
   bit         chk_en;
   int         vectors, miscompares;

   // Three arbiters: fixed priority, rotating, and rotating with NCH not a power of two.
   dm01_break_arbiter_if #(.NCH(4), .CHW(2)) if0 ();
   dm01_break_arbiter_if #(.NCH(4), .CHW(2)) if1 ();
   dm01_break_arbiter_if #(.NCH(3), .CHW(2)) if2 ();

   assign if0.tp4 = tp4_v;  assign if0.b_brk = bbrk_v;  assign if0.stall_clr = sclr_v;
   assign if1.tp4 = tp4_v;  assign if1.b_brk = bbrk_v;  assign if1.stall_clr = sclr_v;
   assign if2.tp4 = tp4_v;  assign if2.b_brk = bbrk_v;  assign if2.stall_clr = sclr_v;
   assign if0.req = req_v[0][3:0];
   assign if1.req = req_v[1][3:0];
   assign if2.req = req_v[2][2:0];

   dm01_break_arbiter #(.NCH(4), .CHW(2), .ROUND_ROBIN(0), .MAX_WAIT(3)) u_fix (
      .clk(clk), .rst(rst), .bus(if0));
   dm01_break_arbiter #(.NCH(4), .CHW(2), .ROUND_ROBIN(1), .MAX_WAIT(15)) u_rr (
      .clk(clk), .rst(rst), .bus(if1));
   dm01_break_arbiter #(.NCH(3), .CHW(2), .ROUND_ROBIN(1), .MAX_WAIT(2)) u_rr3 (
      .clk(clk), .rst(rst), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 waiting for CPU break, 2 break cycle in progress
   int         nch_m [3] = '{4, 4, 3};
   int         rr_m  [3] = '{0, 1, 1};
   int         maxw_m[3] = '{3, 15, 2};
   int         ph[3], win[3], wt[3], ptr[3];
   logic [7:0] ackm[3];
   bit         stl[3];

   function automatic int pick(input logic [7:0] cand, input int n, input int start);
      for (int k = 0; k < n; k++) begin
         if (cand[(start + k) % n]) return (start + k) % n;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         ph[i] = 0; win[i] = 0; wt[i] = 0; ptr[i] = 0; ackm[i] = 8'h00; stl[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i);
      int         n, w, start;
      logic [7:0] rq, served;
      bit         set;
      n     = nch_m[i];
      rq    = req_v[i] & 8'((1 << n) - 1);
      set   = 1'b0;
      start = (rr_m[i] != 0) ? ptr[i] : 0;
      ackm[i] = 8'h00;
      if (ph[i] == 0) begin
         if (tp4_v) begin
            w = pick(rq, n, start);
            if (w >= 0) begin ph[i] = 1; win[i] = w; wt[i] = 0; end
         end
      end else if (ph[i] == 1) begin
         if (bbrk_v) begin
            ph[i] = 2; wt[i] = 0;
         end else if (tp4_v) begin
            if (!rq[win[i]]) begin
               w = pick(rq, n, start);
               wt[i] = 0;
               if (w >= 0) win[i] = w; else begin ph[i] = 0; win[i] = 0; end
            end else begin
               if (wt[i] < 255) wt[i]++;
               if (wt[i] >= maxw_m[i]) set = 1'b1;
            end
         end
      end else begin
         wt[i] = 0;
         if (tp4_v) begin
            served  = 8'(1 << win[i]);
            ackm[i] = served;
            ptr[i]  = (win[i] + 1) % n;
            start   = (rr_m[i] != 0) ? ptr[i] : 0;
            w = pick(rq & ~served, n, start);
            if (w >= 0) begin ph[i] = 1; win[i] = w; end else begin ph[i] = 0; win[i] = 0; end
         end
      end
      stl[i] = set | (stl[i] & ~sclr_v);
   endtask

   task automatic model_all();
      if (rst) model_reset();
      else for (int i = 0; i < 3; i++) model_step(i);
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
      end
   endtask

   task automatic cmp_inst(input int i, input logic brk, input logic [7:0] g, input logic [7:0] c,
                           input logic [7:0] a, input logic bsy, input logic st);
      chk("brk_rq", i, {7'b0, brk}, {7'b0, ph[i] == 1});
      chk("grant",  i, g, (ph[i] != 0) ? 8'(1 << win[i]) : 8'h00);
      chk("chan",   i, c, (ph[i] != 0) ? 8'(win[i]) : 8'h00);
      chk("ack",    i, a, ackm[i]);
      chk("busy",   i, {7'b0, bsy}, {7'b0, ph[i] != 0});
      chk("stall",  i, {7'b0, st}, {7'b0, stl[i]});
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, if0.brk_rq, 8'(if0.grant), 8'(if0.chan), 8'(if0.ack), if0.busy, if0.stall);
         cmp_inst(1, if1.brk_rq, 8'(if1.grant), 8'(if1.chan), 8'(if1.ack), if1.busy, if1.stall);
         cmp_inst(2, if2.brk_rq, 8'(if2.grant), 8'(if2.chan), 8'(if2.ack), if2.busy, if2.stall);
      end
   end

   // One clock: inputs change just after the falling edge, model follows the rising edge.
   task automatic cyc(input logic t, input logic b, input logic s);
      #1;
      tp4_v = t; bbrk_v = b; sclr_v = s;
      @(posedge clk);
      model_all();
      @(negedge clk);
   endtask

   int order [5] = '{0, 1, 2, 3, 0};
   int tcnt;

   initial begin
      vectors = 0; miscompares = 0; chk_en = 1'b0;
      tp4_v = 1'b0; bbrk_v = 1'b0; sclr_v = 1'b0;
      for (int i = 0; i < 3; i++) req_v[i] = 8'h00;
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_grant", 0, 8'(if0.grant), 8'h00);
      chk("rst_busy", 0, {7'b0, if0.busy}, 8'h00);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Basic grant / break / ack, then follow-on winner and withdrawal.
      req_v[0] = 8'b0110;
      cyc(1, 0, 0);
      chk("t1_grant", 0, 8'(if0.grant), 8'h02);
      chk("t1_chan", 0, 8'(if0.chan), 8'h01);
      chk("t1_brk", 0, {7'b0, if0.brk_rq}, 8'h01);
      cyc(0, 1, 0);
      chk("t1_brk_off", 0, {7'b0, if0.brk_rq}, 8'h00);
      cyc(1, 0, 0);
      chk("t1_ack", 0, 8'(if0.ack), 8'h02);
      chk("t1_next", 0, 8'(if0.grant), 8'h04);
      cyc(0, 0, 0);
      chk("t1_ack_1clk", 0, 8'(if0.ack), 8'h00);
      req_v[0] = 8'h00;
      cyc(1, 0, 0);
      chk("t1_idle", 0, {7'b0, if0.busy}, 8'h00);

      // Fixed priority: channel 0 arrives during channel 3's break.
      req_v[0] = 8'b1000;
      cyc(1, 0, 0);
      chk("t3_chan", 0, 8'(if0.chan), 8'h03);
      cyc(0, 1, 0);
      req_v[0] = 8'b1001;
      cyc(0, 0, 0);
      chk("t3_hold", 0, 8'(if0.grant), 8'h08);
      cyc(1, 0, 0);
      chk("t3_ack", 0, 8'(if0.ack), 8'h08);
      chk("t3_grant0", 0, 8'(if0.grant), 8'h01);
      req_v[0] = 8'b0001;
      cyc(0, 1, 0);
      req_v[0] = 8'h00;
      cyc(1, 0, 0);
      chk("t3_ack0", 0, 8'(if0.ack), 8'h01);
      chk("t3_idle", 0, 8'(if0.grant), 8'h00);

      // Withdrawal while pending.
      req_v[0] = 8'b0100;
      cyc(1, 0, 0);
      chk("t4_grant", 0, 8'(if0.grant), 8'h04);
      req_v[0] = 8'h00;
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      chk("t4_grant0", 0, 8'(if0.grant), 8'h00);
      chk("t4_noack", 0, 8'(if0.ack), 8'h00);
      cyc(0, 0, 0);
      chk("t4_noack2", 0, 8'(if0.ack), 8'h00);

      // Stall after MAX_WAIT=3 strobes; set beats clear on the same edge.
      req_v[0] = 8'b0001;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("t5_nostall", 0, {7'b0, if0.stall}, 8'h00);
      cyc(1, 0, 0);
      chk("t5_stall", 0, {7'b0, if0.stall}, 8'h01);
      chk("t5_brk", 0, {7'b0, if0.brk_rq}, 8'h01);
      cyc(0, 0, 1);
      chk("t5_clr", 0, {7'b0, if0.stall}, 8'h00);
      cyc(1, 0, 1);
      chk("t5_setwins", 0, {7'b0, if0.stall}, 8'h01);
      cyc(0, 0, 1);
      req_v[0] = 8'h00;
      cyc(1, 0, 0);

      // Rotating priority, all channels requesting: back-to-back breaks 0,1,2,3,0.
      req_v[1] = 8'b1111;
      cyc(1, 0, 0);
      chk("t2_first", 1, 8'(if1.grant), 8'h01);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 1, 0);
         cyc(1, 0, 0);
         chk("t2_ack", 1, 8'(if1.ack), 8'(1 << order[k]));
         chk("t2_busy", 1, {7'b0, if1.busy}, 8'h01);
      end
      req_v[1] = 8'h00;
      cyc(0, 1, 0);
      cyc(1, 0, 0);

      // Asynchronous reset in the middle of a break.
      req_v[0] = 8'b0010;
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("t6_grant", 0, 8'(if0.grant), 8'h00);
      chk("t6_busy", 0, {7'b0, if0.busy}, 8'h00);
      chk("t6_chan", 0, 8'(if0.chan), 8'h00);
      chk("t6_ack", 0, 8'(if0.ack), 8'h00);
      @(negedge clk);
      #1 rst = 1'b0;
      cyc(1, 0, 0);
      chk("t6_reserve", 0, 8'(if0.grant), 8'h02);
      req_v[0] = 8'h00;

      // Randomised traffic on all three arbiters.
      tcnt = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 3; i++)
            for (int b = 0; b < 4; b++)
               if ($urandom_range(7) == 0) req_v[i][b] = ~req_v[i][b];
         if (n == 1500) rst = 1'b1;
         if (n == 1502) rst = 1'b0;
         if (tcnt == 0) begin
            tcnt = $urandom_range(5, 1);
            cyc(1, $urandom_range(2) == 0, $urandom_range(15) == 0);
         end else begin
            tcnt--;
            cyc(0, $urandom_range(2) == 0, $urandom_range(15) == 0);
         end
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
